traffic_intersection_ctrl: RTL

//  Sequences the lamps of a two-road intersection: main road, side road and a pedestrian crossing.

---
 rtl/traffic_intersection_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection lamp sequencer with pedestrian crossing.
// Moore FSM plus one saturating phase timer; lamps are registered from the next state.
module traffic_intersection_ctrl #(
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned GREEN_MAX = 16,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned WALK_T    = 6,
  parameter int unsigned CNT_W     = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [2:0] state_out
);

  localparam logic [2:0] Red    = 3'b000;
  localparam logic [2:0] Green  = 3'b001;
  localparam logic [2:0] Yellow = 3'b010;

  localparam logic [CNT_W-1:0] GreenMinLast = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GreenMaxLast = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YellowLast   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AllRedLast   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WalkLast     = CNT_W'(WALK_T - 1);

  typedef enum logic [2:0] {
    StMg  = 3'd0,
    StMy  = 3'd1,
    StAr1 = 3'd2,
    StSg  = 3'd3,
    StSy  = 3'd4,
    StAr2 = 3'd5,
    StPw  = 3'd6
  } state_e;

  // Plain vector so an out-of-range code can exist and be recovered from.
  logic [2:0]       state_q;
  state_e           state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_d, walk_end;
  logic [2:0]       main_d, side_d;
  logic             walk_d;

  always_comb begin
    state_d = state_e'(state_q);
    case (state_q)
      StMg:  if (timer_q >= GreenMinLast && (side_req || ped_pending)) state_d = StMy;
      StMy:  if (timer_q == YellowLast) state_d = StAr1;
      StAr1: if (timer_q == AllRedLast) state_d = ped_pending ? StPw : StSg;
      StSg:  if (timer_q == GreenMaxLast || (timer_q >= GreenMinLast && !side_req)) state_d = StSy;
      StSy:  if (timer_q == YellowLast) state_d = StAr2;
      StPw:  if (timer_q == WalkLast) state_d = StAr2;
      StAr2: if (timer_q == AllRedLast) state_d = StMg;
      default: state_d = StAr2;
    endcase

    if (state_d != state_e'(state_q)) timer_d = '0;
    else if (&timer_q)                timer_d = timer_q;
    else                              timer_d = timer_q + 1'b1;

    walk_end = (state_q == StPw) && (timer_q == WalkLast);
    ped_d    = (ped_pending && !walk_end) || ped_req;

    main_d = Red;
    side_d = Red;
    walk_d = 1'b0;
    case (state_d)
      StMg:    main_d = Green;
      StMy:    main_d = Yellow;
      StSg:    side_d = Green;
      StSy:    side_d = Yellow;
      StPw:    walk_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StMg;
      timer_q     <= '0;
      ped_pending <= 1'b0;
      main_light  <= Green;
      side_light  <= Red;
      ped_walk    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ped_pending <= ped_d;
      main_light  <= main_d;
      side_light  <= side_d;
      ped_walk    <= walk_d;
    end
  end

  assign state_out = state_q;

endmodule
